// File: rtl/mips_mem_pkg.sv
// Shared types for the memory access controller:
// op codes, FSM states, request bundle, range check.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  localparam int DATA_WORDS_DEF  = 32;
  localparam int INSTR_WORDS_DEF = 33;
  localparam int CNT_W           = 4;

  typedef struct packed {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // A request is rejected when misaligned, reserved,
  // or when its word index falls past the target memory.
  function automatic logic req_bad(
    input op_e         op,
    input logic [31:0] addr,
    input int unsigned dwords,
    input int unsigned iwords
  );
    logic [31:0] idx;
    logic [31:0] lim;
    idx = {2'b00, addr[31:2]};
    lim = (op == OP_FETCH) ? iwords : dwords;
    return (addr[1:0] != 2'b00)
        || (op == OP_RSVD)
        || (idx >= lim);
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Core-side request/response controller for split
// instruction/data memory with a fixed read wait.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int RD_WAIT     = 1,
  parameter int DATA_WORDS  = DATA_WORDS_DEF,
  parameter int INSTR_WORDS = INSTR_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rd
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(RD_WAIT - 1);

  state_e           state;
  req_t             r;
  logic [CNT_W-1:0] cnt;

  op_e  op_in;
  logic bad;
  logic hs_req;
  logic hs_rsp;
  logic in_acc;

  assign op_in  = op_e'(req_op);
  assign bad    = req_bad(op_in, req_addr,
                          DATA_WORDS, INSTR_WORDS);
  assign hs_req = req_valid && req_ready;
  assign hs_rsp = rsp_valid && rsp_ready;

  // Memory strobes come straight from the latched
  // request, so they vanish the moment state resets.
  assign in_acc = (state == S_ACCESS)
               && (r.addr[1:0] == 2'b00);
  assign mem_a  = in_acc ? {2'b00, r.addr[31:2]} : '0;
  assign mem_we = in_acc && (r.op == OP_STORE);
  assign mem_wd = mem_we ? r.wdata : '0;
  assign mem_re = in_acc && (r.op == OP_LOAD);

  // Request FSM with wait counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      r         <= '0;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ir        <= '0;
      mdr       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (hs_req) begin
            req_ready <= 1'b0;
            r.op      <= op_in;
            r.addr    <= req_addr;
            r.wdata   <= req_wdata;
            rsp_err   <= bad;
            if (bad) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= S_ACCESS;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_ACCESS: begin
          if (r.op == OP_STORE || cnt == '0) begin
            if (r.op == OP_FETCH) begin
              ir <= mem_rd;
            end else if (r.op == OP_LOAD) begin
              mdr <= mem_rd;
            end
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (hs_rsp) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench: two controllers (read wait 1 and 3) share
// stimulus; a scoreboard holds expected responses.
module tb_mem_access_ctrl;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        rq1, rv1, re1, we1, er1;
  logic        rq3, rv3, re3, we3, er3;
  logic [31:0] ir1, mdr1, ma1, wd1, rd1;
  logic [31:0] ir3, mdr3, ma3, wd3, rd3;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] mm   [0:63];
  logic [31:0] m_ir, m_mdr;

  typedef struct {
    logic        err;
    logic [31:0] ir;
    logic [31:0] mdr;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  int vecs = 0;
  int fails = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h2010_0005;
    if (i == 32) return 32'h0C00_0042;
    return 32'hA500_0000 | 32'(i);
  endfunction

  assign rd1 = mem1[ma1[5:0]];
  assign rd3 = mem3[ma3[5:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem1[i] <= init_word(i);
    end else if (we1) begin
      mem1[ma1[5:0]] <= wd1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem3[i] <= init_word(i);
    end else if (we3) begin
      mem3[ma3[5:0]] <= wd3;
    end
  end

  mem_access_ctrl #(.RD_WAIT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rq1),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_err(er1), .ir(ir1), .mdr(mdr1),
    .mem_a(ma1), .mem_wd(wd1), .mem_we(we1),
    .mem_re(re1), .mem_rd(rd1)
  );

  mem_access_ctrl #(.RD_WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rq3),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_ready(rsp_ready),
    .rsp_err(er3), .ir(ir3), .mdr(mdr3),
    .mem_a(ma3), .mem_wd(wd3), .mem_we(we3),
    .mem_re(re3), .mem_rd(rd3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mm[i] = init_word(i);
    m_ir = '0;
    m_mdr = '0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(rq1 && rq3) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", {31'b0, rq1 && rq3}, 32'd1);
  endtask

  task automatic xact(input logic [1:0]  op,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input int          hold);
    logic        bad;
    logic [31:0] idx, lim, irs;
    exp_t        e, e1, e3;
    int          t1, t3, c_re1, c_re3, c_we1, c_we3;
    idx = {2'b00, addr[31:2]};
    lim = (op == 2'b00) ? 32'd33 : 32'd32;
    bad = (addr[1:0] != 2'b00) || (op == 2'b11)
       || (idx >= lim);
    if (!bad) begin
      if (op == 2'b00) m_ir = mm[idx[5:0]];
      if (op == 2'b01) m_mdr = mm[idx[5:0]];
      if (op == 2'b10) mm[idx[5:0]] = wd;
    end
    e.err = bad;
    e.ir = m_ir;
    e.mdr = m_mdr;
    e.lat = bad ? 1 : 2;
    q1.push_back(e);
    e.lat = bad ? 1 : (op == 2'b10) ? 2 : 4;
    q3.push_back(e);

    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;

    t1 = 0; t3 = 0;
    c_re1 = 0; c_re3 = 0; c_we1 = 0; c_we3 = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 1) begin
        chk("mem_a1", ma1, bad ? 32'd0 : idx);
        chk("mem_a3", ma3, bad ? 32'd0 : idx);
      end
      if (re1) c_re1++;
      if (re3) c_re3++;
      if (we1) begin
        c_we1++;
        chk("mem_wd1", wd1, wd);
      end
      if (we3) begin
        c_we3++;
        chk("mem_wd3", wd3, wd);
      end
      if (rv1 && t1 == 0) t1 = n;
      if (rv3 && t3 == 0) t3 = n;
      if (t1 != 0 && t3 != 0) break;
      @(negedge clk);
    end

    e1 = q1.pop_front();
    e3 = q3.pop_front();
    chk("lat1", t1, e1.lat);
    chk("lat3", t3, e3.lat);
    chk("err1", {31'b0, er1}, {31'b0, e1.err});
    chk("err3", {31'b0, er3}, {31'b0, e3.err});
    chk("ir1", ir1, e1.ir);
    chk("ir3", ir3, e3.ir);
    chk("mdr1", mdr1, e1.mdr);
    chk("mdr3", mdr3, e3.mdr);
    chk("re_cnt1", c_re1,
        (!bad && op == 2'b01) ? 1 : 0);
    chk("re_cnt3", c_re3,
        (!bad && op == 2'b01) ? 3 : 0);
    chk("we_cnt1", c_we1,
        (!bad && op == 2'b10) ? 1 : 0);
    chk("we_cnt3", c_we3,
        (!bad && op == 2'b10) ? 1 : 0);

    irs = ir3;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_op = 2'b01;
      req_addr = 32'h0000_0010;
      @(negedge clk);
      chk("hold_rv1", {31'b0, rv1}, 32'd1);
      chk("hold_rv3", {31'b0, rv3}, 32'd1);
      chk("hold_rq", {31'b0, rq1 | rq3}, 32'd0);
      chk("hold_ir", ir3, irs);
      chk("hold_err", {31'b0, er3}, {31'b0, e3.err});
    end
    req_valid = 1'b0;

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rv_clr", {31'b0, rv1 | rv3}, 32'd0);
    chk("rq_back", {31'b0, rq1 & rq3}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_rv", {31'b0, rv1 | rv3}, 32'd0);
    chk("rst_ir", ir1 | ir3, 32'd0);
    chk("rst_mdr", mdr1 | mdr3, 32'd0);
    chk("rst_mem",
        {30'b0, we1 | we3, re1 | re3}, 32'd0);
    chk("rst_ma", ma1 | ma3, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {31'b0, rq1 & rq3}, 32'd1);

    xact(2'b00, 32'h0000_0008, 32'h0, 0);
    xact(2'b10, 32'h0000_007C, 32'hDEAD_BEEF, 0);
    xact(2'b01, 32'h0000_007C, 32'h0, 0);
    xact(2'b01, 32'h0000_0006, 32'h0, 0);
    xact(2'b01, 32'h0000_0080, 32'h0, 0);
    xact(2'b11, 32'h0000_0010, 32'h0, 0);
    xact(2'b10, 32'h0000_0081, 32'h1111_2222, 0);
    xact(2'b00, 32'h0000_0080, 32'h0, 0);
    xact(2'b00, 32'h0000_0084, 32'h0, 0);
    xact(2'b01, 32'h0000_0014, 32'h0, 0);
    xact(2'b00, 32'h0000_0008, 32'h0, 5);
    xact(2'b01, 32'h0000_007C, 32'h0, 0);

    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_op = 2'b10;
    req_addr = 32'h0000_0040;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_we_on", {31'b0, we1 & we3}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_we_off", {31'b0, we1 | we3}, 32'd0);
    chk("mid_ma", ma1 | ma3, 32'd0);
    chk("mid_wd", wd1 | wd3, 32'd0);
    chk("mid_ir", ir1 | ir3, 32'd0);
    chk("mid_mdr", mdr1 | mdr3, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rq", {31'b0, rq1 & rq3}, 32'd1);
    chk("rel_rv", {31'b0, rv1 | rv3}, 32'd0);
    chk("rel_ir", ir1 | ir3, 32'd0);
    chk("rel_mdr", mdr1 | mdr3, 32'd0);

    xact(2'b01, 32'h0000_0040, 32'h0, 0);
    xact(2'b00, 32'h0000_0008, 32'h0, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule
